// File: rtl/alu_seq_pkg.sv
// Shared ALU op-code and FSM-state definitions for alu_seq and the ALU-control decoder.
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_REM  = 4'd5;
    localparam logic [3:0] ALU_DIVU = 4'd6;
    localparam logic [3:0] ALU_REMU = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_XOR  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True for the four ops that use the iterative divider.
    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        case (op)
            ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the signed divide ops that need magnitude/sign handling.
    function automatic logic is_signed_div_op(input logic [3:0] op);
        logic r;
        case (op)
            ALU_DIV, ALU_REM: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the datapath and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_seq_div_core.sv
// Unsigned restoring divider: load captures operands, each step retires one quotient bit.
// The next-state quotient/remainder are exposed so the owner can capture the final
// values on the same edge as the last step.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_next_o,
    output logic [WIDTH-1:0] rem_next_o
);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   trial_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        trial_s     = rem_shift_s - {1'b0, dvs_q};
        if (trial_s[WIDTH] == 1'b0) begin
            quo_next_o = {quo_q[WIDTH-2:0], 1'b1};
            rem_next_o = trial_s[WIDTH-1:0];
        end else begin
            quo_next_o = {quo_q[WIDTH-2:0], 1'b0};
            rem_next_o = rem_shift_s[WIDTH-1:0];
        end
    end

    // Select load, step or hold for the divider registers.
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = {WIDTH{1'b0}};
            dvs_d = divisor_i;
        end else if (step_i) begin
            quo_d = quo_next_o;
            rem_d = rem_next_o;
        end else begin
            quo_d = quo_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q <= {WIDTH{1'b0}};
            rem_q <= {WIDTH{1'b0}};
            dvs_q <= {WIDTH{1'b0}};
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops complete on the accept edge, DIV/REM variants
// iterate WIDTH cycles in div_core with sign correction folded into the last edge.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] single_res_s;
    logic [WIDTH-1:0] a_abs_s, b_abs_s;
    logic             a_neg_s, b_neg_s;
    logic             div_load_s, div_step_s;
    logic [WIDTH-1:0] quo_next_s, rem_next_s;
    logic [WIDTH-1:0] div_res_s;

    // Results of ops that finish on the accept edge, including divide-by-zero.
    always_comb begin
        case (bus.op)
            ALU_ADD:  single_res_s = bus.src_a + bus.src_b;
            ALU_SUB:  single_res_s = bus.src_a - bus.src_b;
            ALU_AND:  single_res_s = bus.src_a & bus.src_b;
            ALU_OR:   single_res_s = bus.src_a | bus.src_b;
            ALU_XOR:  single_res_s = bus.src_a ^ bus.src_b;
            ALU_SLT:  single_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            ALU_SLTU: single_res_s = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
            ALU_DIV, ALU_DIVU: single_res_s = {WIDTH{1'b1}};
            ALU_REM, ALU_REMU: single_res_s = bus.src_a;
            default:  single_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Operand magnitudes for the unsigned divider core.
    always_comb begin
        a_neg_s = is_signed_div_op(bus.op) & bus.src_a[WIDTH-1];
        b_neg_s = is_signed_div_op(bus.op) & bus.src_b[WIDTH-1];
        a_abs_s = a_neg_s ? (-bus.src_a) : bus.src_a;
        b_abs_s = b_neg_s ? (-bus.src_b) : bus.src_b;
    end

    // Sign-corrected divider result taken from the final step's next values.
    always_comb begin
        case (op_q)
            ALU_DIV:  div_res_s = (a_neg_q ^ b_neg_q) ? (-quo_next_s) : quo_next_s;
            ALU_REM:  div_res_s = a_neg_q ? (-rem_next_s) : rem_next_s;
            ALU_DIVU: div_res_s = quo_next_s;
            default:  div_res_s = rem_next_s;
        endcase
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        div_load_s  = 1'b0;
        div_step_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_div_op(bus.op) && (bus.src_b != {WIDTH{1'b0}})) begin
                        div_load_s = 1'b1;
                        op_d       = bus.op;
                        a_neg_d    = a_neg_s;
                        b_neg_d    = b_neg_s;
                        cnt_d      = {CNT_W{1'b0}};
                        state_d    = S_DIV;
                    end else begin
                        result_d    = single_res_s;
                        zero_d      = (single_res_s == {WIDTH{1'b0}});
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                div_step_s = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d       = {CNT_W{1'b0}};
                    result_d    = div_res_s;
                    zero_d      = (div_res_s == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial divide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            op_q        <= ALU_ADD;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (div_load_s),
        .step_i     (div_step_s),
        .dividend_i (a_abs_s),
        .divisor_i  (b_abs_s),
        .quo_next_o (quo_next_s),
        .rem_next_o (rem_next_s)
    );

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus32 ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32.slave));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n), .bus(bus8.slave));

    // Issue one op on the 32-bit unit, check result, zero, latency and handshake return.
    task automatic run_op32(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_wait);
        int waited;
        n_checks++;
        if (bus32.in_ready !== 1'b1) $display("FAIL %s in_ready: got %b exp 1", name, bus32.in_ready);
        else n_pass++;
        bus32.in_valid = 1'b1; bus32.op = op; bus32.src_a = a; bus32.src_b = b;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0; bus32.op = 4'($urandom); bus32.src_a = $urandom; bus32.src_b = $urandom;
        waited = 0;
        while (bus32.out_valid !== 1'b1 && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        n_checks++;
        if (waited !== exp_wait) $display("FAIL %s latency: got %0d exp %0d", name, waited, exp_wait);
        else n_pass++;
        n_checks++;
        if (bus32.result !== exp) $display("FAIL %s result: got %h exp %h", name, bus32.result, exp);
        else n_pass++;
        n_checks++;
        if (bus32.zero !== (exp == 32'd0)) $display("FAIL %s zero: got %b exp %b", name, bus32.zero, (exp == 32'd0));
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus32.out_valid !== 1'b0) $display("FAIL %s out_valid after handshake: got %b exp 0", name, bus32.out_valid);
        else n_pass++;
    endtask

    // Same as run_op32 for the 8-bit unit.
    task automatic run_op8(input string name, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp, input int exp_wait);
        int waited;
        bus8.in_valid = 1'b1; bus8.op = op; bus8.src_a = a; bus8.src_b = b;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0; bus8.op = 4'($urandom); bus8.src_a = 8'($urandom); bus8.src_b = 8'($urandom);
        waited = 0;
        while (bus8.out_valid !== 1'b1 && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        n_checks++;
        if (waited !== exp_wait) $display("FAIL %s latency: got %0d exp %0d", name, waited, exp_wait);
        else n_pass++;
        n_checks++;
        if (bus8.result !== exp) $display("FAIL %s result: got %h exp %h", name, bus8.result, exp);
        else n_pass++;
        n_checks++;
        if (bus8.zero !== (exp == 8'd0)) $display("FAIL %s zero: got %b exp %b", name, bus8.zero, (exp == 8'd0));
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus8.out_valid !== 1'b0) $display("FAIL %s out_valid after handshake: got %b exp 0", name, bus8.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus32.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b exp 1", bus32.in_ready); else n_pass++;
        n_checks++;
        if (bus32.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b exp 0", bus32.out_valid); else n_pass++;
        n_checks++;
        if (bus32.result !== 32'd0) $display("FAIL reset result: got %h exp 0", bus32.result); else n_pass++;
        n_checks++;
        if (bus32.zero !== 1'b0) $display("FAIL reset zero: got %b exp 0", bus32.zero); else n_pass++;
        n_checks++;
        if (bus8.out_valid !== 1'b0) $display("FAIL reset8 out_valid: got %b exp 0", bus8.out_valid); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        run_op32("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
        run_op32("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);
        run_op32("sltu_big", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
        run_op32("sub_neg", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
        run_op32("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);
        run_op32("or", ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0);
        run_op32("xor", ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 0);
        run_op32("op12", 4'd12, 32'h1234_5678, 32'h1, 32'h0, 0);
    endtask

    task automatic test_divide();
        run_op32("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run_op32("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run_op32("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32);
        run_op32("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 32);
        run_op32("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
        run_op32("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
    endtask

    task automatic test_div_edge();
        run_op32("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
        run_op32("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32);
        run_op32("divu_by0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
        run_op32("remu_by0", ALU_REMU, 32'd9, 32'd0, 32'd9, 0);
        run_op32("div_by0", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_backpressure();
        int waited;
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b1; bus32.op = ALU_DIVU; bus32.src_a = 32'd100; bus32.src_b = 32'd7;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        waited = 0;
        while (bus32.out_valid !== 1'b1 && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        n_checks++;
        if (waited !== 32) $display("FAIL bp latency: got %0d exp 32", waited); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus32.result !== 32'd14) $display("FAIL bp hold result[%0d]: got %h exp 0000000e", i, bus32.result); else n_pass++;
            n_checks++;
            if (bus32.in_ready !== 1'b0) $display("FAIL bp in_ready[%0d]: got %b exp 0", i, bus32.in_ready); else n_pass++;
            n_checks++;
            if (bus32.out_valid !== 1'b1) $display("FAIL bp out_valid[%0d]: got %b exp 1", i, bus32.out_valid); else n_pass++;
            bus32.in_valid = (i % 2 == 0); bus32.op = ALU_ADD; bus32.src_a = 32'd1; bus32.src_b = 32'd1;
            @(posedge clk); #1;
        end
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus32.out_valid !== 1'b0) $display("FAIL bp release out_valid: got %b exp 0", bus32.out_valid); else n_pass++;
        n_checks++;
        if (bus32.result !== 32'd14) $display("FAIL bp release result: got %h exp 0000000e", bus32.result); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus32.out_valid !== 1'b0) $display("FAIL bp ignored pulse: got %b exp 0", bus32.out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_divide();
        bus32.in_valid = 1'b1; bus32.op = ALU_DIV; bus32.src_a = 32'hFFFF_FFF9; bus32.src_b = 32'd2;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus32.out_valid !== 1'b0) $display("FAIL midrst out_valid: got %b exp 0", bus32.out_valid); else n_pass++;
        n_checks++;
        if (bus32.result !== 32'd0) $display("FAIL midrst result: got %h exp 0", bus32.result); else n_pass++;
        n_checks++;
        if (bus32.in_ready !== 1'b1) $display("FAIL midrst in_ready: got %b exp 1", bus32.in_ready); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op32("add_after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 0);
    endtask

    task automatic test_width8();
        run_op8("w8_add_wrap", ALU_ADD, 8'hFF, 8'h01, 8'h00, 0);
        run_op8("w8_div_m7_2", ALU_DIV, 8'hF9, 8'h02, 8'hFD, 8);
        run_op8("w8_rem_m7_2", ALU_REM, 8'hF9, 8'h02, 8'hFF, 8);
        run_op8("w8_divu_100_7", ALU_DIVU, 8'd100, 8'd7, 8'd14, 8);
        run_op8("w8_remu_100_7", ALU_REMU, 8'd100, 8'd7, 8'd2, 8);
        run_op8("w8_div_ovf", ALU_DIV, 8'h80, 8'hFF, 8'h80, 8);
    endtask

    initial begin
        rst_n = 1'b0;
        bus32.in_valid = 1'b0; bus32.op = 4'd0; bus32.src_a = 32'd0; bus32.src_b = 32'd0; bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = 4'd0; bus8.src_a = 8'd0; bus8.src_b = 8'd0; bus8.out_ready = 1'b1;
        test_reset();
        test_single_cycle();
        test_divide();
        test_div_edge();
        test_backpressure();
        test_reset_mid_divide();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
